// File: rtl/nlp16_pkg.sv
// Shared types for the ALU writeback stage: packed flag word and writeback entry.
// The package widths must match the DATA_W / REG_AW parameters of alu_writeback.
package nlp16_pkg;

    localparam int NLP_DATA_W = 16;
    localparam int NLP_REG_AW = 4;

    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        logic c;
        logic s;
        logic v;
        logic z;
    } flag_t;

    typedef struct packed {
        logic [NLP_DATA_W-1:0] data;
        logic [NLP_REG_AW-1:0] dst;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: DEPTH entries of wb_entry_t, pointers wrap modulo DEPTH (power of 2).
// The ready output is registered from the next count so it has no combinational path from pop.
import nlp16_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_entry,
    output wb_entry_t o_head,
    output logic      o_valid,
    output logic      o_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (i_push && !i_pop)
            count_next = count + CNT_W'(1);
        else if (i_pop && !i_push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_ready <= 1'b1;
        end else begin
            if (i_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (i_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            o_ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (i_push)
            mem[wr_ptr] <= i_entry;
    end

    assign o_head  = mem[rd_ptr];
    assign o_valid = (count != '0);

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: architectural flag register plus buffered regfile write port.
// Optional macro WB_BYPASS_EN lets an entry skip the empty FIFO straight to o_wb_*.
import nlp16_pkg::*;

module alu_writeback #(
    parameter int         DATA_W   = 16,
    parameter int         REG_AW   = 4,
    parameter int         DEPTH    = 2,
    parameter logic [3:0] FLAG_RST = 4'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_flag,
    input  logic [REG_AW-1:0] i_dst,
    input  logic              i_wr_en,
    input  logic              i_flag_en,
    input  logic              i_flag_wr,
    input  logic [3:0]        i_flag_wdata,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [REG_AW-1:0] o_wb_dst,
    output logic [3:0]        o_flag,
    output logic              o_carry
);
    flag_t     flag_q;
    wb_entry_t in_entry;
    wb_entry_t head;
    logic      accept;
    logic      push;
    logic      bypass;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_valid;
    logic      fifo_ready;

    assign accept        = i_valid & fifo_ready;
    assign push          = accept & i_wr_en;
    assign in_entry.data = i_data;
    assign in_entry.dst  = i_dst;

`ifdef WB_BYPASS_EN
    assign bypass = !fifo_valid & push & i_wb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = push & !bypass;
    assign fifo_pop  = fifo_valid & i_wb_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_entry (in_entry),
        .o_head  (head),
        .o_valid (fifo_valid),
        .o_ready (fifo_ready)
    );

    assign o_ready    = fifo_ready;
    assign o_wb_valid = fifo_valid | bypass;
    assign o_wb_data  = bypass ? i_data : head.data;
    assign o_wb_dst   = bypass ? i_dst  : head.dst;

    // Explicit load beats the ALU update; flags change at accept, not at writeback.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            flag_q <= flag_t'(FLAG_RST);
        else if (i_flag_wr)
            flag_q <= flag_t'(i_flag_wdata);
        else if (accept && i_flag_en)
            flag_q <= flag_t'(i_flag);
    end

    assign o_flag  = flag_q;
    assign o_carry = o_flag[FLAG_C];

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table plus randomized run against a queue model.
module tb_alu_writeback;
    localparam int         DEPTH    = 2;
    localparam logic [3:0] FLAG_RST = 4'h0;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_wr_en, i_flag_en, i_flag_wr, o_wb_valid, i_wb_ready, o_carry;
    logic [15:0] i_data, o_wb_data;
    logic [3:0]  i_flag, i_dst, i_flag_wdata, o_wb_dst, o_flag;

    alu_writeback #(.DATA_W(16), .REG_AW(4), .DEPTH(DEPTH), .FLAG_RST(FLAG_RST)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_flag(i_flag), .i_dst(i_dst), .i_wr_en(i_wr_en),
        .i_flag_en(i_flag_en), .i_flag_wr(i_flag_wr), .i_flag_wdata(i_flag_wdata),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_data(o_wb_data),
        .o_wb_dst(o_wb_dst), .o_flag(o_flag), .o_carry(o_carry)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, valid;
        logic [15:0] data;
        logic [3:0]  flag, dst;
        logic        wr, fen, fwr;
        logic [3:0]  fwd;
        logic        wbr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [3:0]  e_flag;
        logic        e_ready, e_wbv;
        logic [15:0] e_data;
        logic [3:0]  e_dst;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dst;
    } ent_t;

    int n_cmp = 0;
    int n_fail = 0;

    ent_t       m_q[$];
    logic [3:0] m_flag = FLAG_RST;

    function automatic stim_t mk(logic rst, logic valid, logic [15:0] data, logic [3:0] flag, logic [3:0] dst,
                                 logic wr, logic fen, logic fwr, logic [3:0] fwd, logic wbr);
        stim_t s;
        s.rst = rst; s.valid = valid; s.data = data; s.flag = flag; s.dst = dst;
        s.wr = wr; s.fen = fen; s.fwr = fwr; s.fwd = fwd; s.wbr = wbr;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_bypass(stim_t s);
`ifdef WB_BYPASS_EN
        return !s.rst && m_q.size() == 0 && s.valid && s.wr && s.wbr && (m_q.size() != DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // Outputs expected during the current cycle, given the model state and the inputs now applied.
    task automatic check_model(input stim_t s);
        bit byp = model_bypass(s);
        chk("mdl_ready", {31'd0, o_ready}, {31'd0, m_q.size() != DEPTH});
        chk("mdl_flag", {28'd0, o_flag}, {28'd0, m_flag});
        chk("mdl_carry", {31'd0, o_carry}, {31'd0, m_flag[3]});
        chk("mdl_wbv", {31'd0, o_wb_valid}, {31'd0, byp || m_q.size() != 0});
        if (byp) begin
            chk("mdl_byp_data", {16'd0, o_wb_data}, {16'd0, s.data});
            chk("mdl_byp_dst", {28'd0, o_wb_dst}, {28'd0, s.dst});
        end else if (m_q.size() != 0) begin
            chk("mdl_data", {16'd0, o_wb_data}, {16'd0, m_q[0].data});
            chk("mdl_dst", {28'd0, o_wb_dst}, {28'd0, m_q[0].dst});
        end
    endtask

    task automatic model_update(input stim_t s);
        bit accept, bypass_now;
        ent_t e;
        if (s.rst) begin
            m_q.delete();
            m_flag = FLAG_RST;
            return;
        end
        accept     = s.valid && (m_q.size() != DEPTH);
        bypass_now = model_bypass(s);
        if (!bypass_now) begin
            if (m_q.size() != 0 && s.wbr)
                void'(m_q.pop_front());
            if (accept && s.wr) begin
                e.data = s.data;
                e.dst  = s.dst;
                m_q.push_back(e);
            end
        end
        if (s.fwr)
            m_flag = s.fwd;
        else if (accept && s.fen)
            m_flag = s.flag;
    endtask

    task automatic drive(input stim_t s);
        i_rst = s.rst; i_valid = s.valid; i_data = s.data; i_flag = s.flag; i_dst = s.dst;
        i_wr_en = s.wr; i_flag_en = s.fen; i_flag_wr = s.fwr; i_flag_wdata = s.fwd; i_wb_ready = s.wbr;
    endtask

    task automatic step(input stim_t s, input bit do_check);
        @(negedge i_clk);
        drive(s);
        #1;
        if (do_check)
            check_model(s);
        @(posedge i_clk);
        model_update(s);
        #1;
    endtask

    vec_t tbl[15];

    initial begin
        stim_t idle;
        idle = mk(0, 0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1);
        //                rst v  data      flag     dst   wr fen fwr fwd    wbr      e_flag  rdy wbv data      dst
        tbl[0]  = '{mk(1, 0, 16'h0000, 4'b0000, 4'd0, 0, 0, 0, 4'h0, 1), 4'h0,   1,  0,  16'h0000, 4'd0};
        tbl[1]  = '{mk(0, 1, 16'h1234, 4'b1000, 4'd3, 1, 1, 0, 4'h0, 1), 4'h8,   1,  1,  16'h1234, 4'd3};
        tbl[2]  = '{idle,                                                 4'h8,   1,  0,  16'h0000, 4'd0};
        tbl[3]  = '{mk(0, 1, 16'hAAAA, 4'b0010, 4'd1, 1, 1, 0, 4'h0, 0), 4'h2,   1,  1,  16'hAAAA, 4'd1};
        tbl[4]  = '{mk(0, 1, 16'hBBBB, 4'b0100, 4'd2, 1, 1, 0, 4'h0, 0), 4'h4,   0,  1,  16'hAAAA, 4'd1};
        tbl[5]  = '{mk(0, 1, 16'hCCCC, 4'b1111, 4'd5, 1, 1, 0, 4'h0, 0), 4'h4,   0,  1,  16'hAAAA, 4'd1};
        tbl[6]  = '{idle,                                                 4'h4,   1,  1,  16'hBBBB, 4'd2};
        tbl[7]  = '{idle,                                                 4'h4,   1,  0,  16'h0000, 4'd0};
        tbl[8]  = '{mk(0, 1, 16'hDEAD, 4'b0001, 4'd4, 0, 1, 0, 4'h0, 1), 4'h1,   1,  0,  16'h0000, 4'd0};
        tbl[9]  = '{mk(0, 1, 16'h5A5A, 4'b1001, 4'd7, 1, 1, 1, 4'h4, 0), 4'h4,   1,  1,  16'h5A5A, 4'd7};
        tbl[10] = '{mk(0, 1, 16'h0F0F, 4'b0000, 4'd9, 1, 0, 0, 4'h0, 0), 4'h4,   0,  1,  16'h5A5A, 4'd7};
        tbl[11] = '{mk(1, 0, 16'h0000, 4'b0000, 4'd0, 0, 0, 0, 4'h0, 0), 4'h0,   1,  0,  16'h0000, 4'd0};
        tbl[12] = '{mk(0, 0, 16'h0000, 4'b0000, 4'd0, 0, 0, 1, 4'hA, 1), 4'hA,   1,  0,  16'h0000, 4'd0};
        tbl[13] = '{mk(0, 1, 16'h0001, 4'b1111, 4'd0, 1, 0, 0, 4'h0, 1), 4'hA,   1,  1,  16'h0001, 4'd0};
        tbl[14] = '{idle,                                                 4'hA,   1,  0,  16'h0000, 4'd0};

        drive(mk(1, 0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0));
        step(mk(1, 0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0), 0);
        step(mk(1, 0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0), 0);

        // Directed table: expectations are the state just after the clock edge of each vector.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].s, 1);
            chk($sformatf("tbl%0d_flag", i), {28'd0, o_flag}, {28'd0, tbl[i].e_flag});
            chk($sformatf("tbl%0d_carry", i), {31'd0, o_carry}, {31'd0, tbl[i].e_flag[3]});
            chk($sformatf("tbl%0d_ready", i), {31'd0, o_ready}, {31'd0, tbl[i].e_ready});
`ifndef WB_BYPASS_EN
            chk($sformatf("tbl%0d_wbv", i), {31'd0, o_wb_valid}, {31'd0, tbl[i].e_wbv});
            if (tbl[i].e_wbv) begin
                chk($sformatf("tbl%0d_data", i), {16'd0, o_wb_data}, {16'd0, tbl[i].e_data});
                chk($sformatf("tbl%0d_dst", i), {28'd0, o_wb_dst}, {28'd0, tbl[i].e_dst});
            end
`endif
        end

        // Full FIFO then reset mid-operation: entries discarded, ready restored next cycle.
        step(mk(0, 1, 16'h1111, 4'h0, 4'd1, 1, 0, 0, 4'h0, 0), 1);
        step(mk(0, 1, 16'h2222, 4'h0, 4'd2, 1, 0, 0, 4'h0, 0), 1);
        chk("full_ready", {31'd0, o_ready}, 32'd0);
        step(mk(1, 1, 16'h3333, 4'h0, 4'd3, 1, 0, 0, 4'h0, 0), 1);
        chk("rst_mid_wbv", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);

`ifdef WB_BYPASS_EN
        // Empty FIFO with regfile ready: entry visible in the same cycle as i_valid.
        @(negedge i_clk);
        drive(mk(0, 1, 16'hBEEF, 4'h0, 4'd6, 1, 0, 0, 4'h0, 1));
        #1;
        chk("byp_wbv", {31'd0, o_wb_valid}, 32'd1);
        chk("byp_data", {16'd0, o_wb_data}, 32'h0000BEEF);
        @(posedge i_clk);
        model_update(mk(0, 1, 16'hBEEF, 4'h0, 4'd6, 1, 0, 0, 4'h0, 1));
        #1;
`endif

        // Randomized run against the queue model.
        for (int n = 0; n < 600; n++) begin
            stim_t s;
            s = mk(($urandom_range(63) == 0), ($urandom_range(3) != 0), 16'($urandom), 4'($urandom),
                   4'($urandom), ($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(7) == 0),
                   4'($urandom), ($urandom_range(2) != 0));
            step(s, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
